mem_stage_pipe: RTL

Parametrised memory (MEM) stage of the pipelined CPU, sitting between execute and write-back. It owns the data memory and supports byte/halfword/word loads and stores with sign or zero extension. Loads have a configurable read latency, during which the stage stalls upstream. Results are registered into the MEM/WB pipeline register, and a combinational forwarding value is provided for the hazard unit.

---
 rtl/mem_stage_pkg.sv | 68 ++++++
 rtl/data_mem_be.sv | 31 +++
 rtl/mem_stage_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and byte-lane helpers for the MEM pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Wide enough for a remaining-latency count up to 3.
    localparam int CNT_W = 3;

    // An access is aligned when its low address bits fit its size.
    // Size 3 behaves exactly like a word access.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addrLow[0];
            default: ok = (addrLow == 2'b00);
        endcase
        return ok;
    endfunction

    // Shift the addressed lane(s) down to bit 0, then sign or zero extend.
    function automatic logic [31:0] loadExtract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  addrLow,
                                                input logic        zeroExt);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {addrLow, 3'b000};
        case (size)
            SZ_BYTE: res = zeroExt ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: res = zeroExt ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: res = shifted;
        endcase
        return res;
    endfunction

    // Little-endian byte enables for a store of the given size.
    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLow);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addrLow;
            SZ_HALF: be = addrLow[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the byte enables pick the right copy.
    function automatic logic [31:0] storeLanes(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_mem_be.sv
// Word-wide data memory with per-byte write enables.
// Writes land on the clock edge; reads are combinational, so a store
// is visible to an access in the following cycle.
module data_mem_be #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] memArray [MEM_DEPTH];

    // Update only the enabled byte lanes of the addressed word; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be_i[lane]) begin
                    memArray[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
                end
            end
        end
    end

    assign rdata_o = memArray[addr_i];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: data memory access with configurable load latency,
// byte/half/word support, forwarding value and the MEM/WB register.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [DATA_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rt_mem,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    output logic                  stall,
    output logic [DATA_W-1:0]     write_data_fwd,
    output logic                  fwd_valid,
    output logic [DATA_W-1:0]     write_to_reg,
    output logic [REG_ADDR_W-1:0] rt_wr,
    output logic [REG_ADDR_W-1:0] rd_wr,
    output logic                  wr_valid,
    output logic                  reg_write_wr,
    output logic                  misalign_wr
);

    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam bit LONG_LAT = (MEM_LATENCY > 1);

    mem_state_t            state_q,        state_d;
    logic [CNT_W-1:0]      cnt_q,          cnt_d;
    logic [DATA_W-1:0]     capAddr_q,      capAddr_d;
    logic [1:0]            capSize_q,      capSize_d;
    logic                  capUnsigned_q,  capUnsigned_d;
    logic                  capRegWrite_q,  capRegWrite_d;
    logic [REG_ADDR_W-1:0] capRt_q,        capRt_d;
    logic [REG_ADDR_W-1:0] capRd_q,        capRd_d;
    logic [DATA_W-1:0]     writeToReg_q,   writeToReg_d;
    logic [REG_ADDR_W-1:0] rtWr_q,         rtWr_d;
    logic [REG_ADDR_W-1:0] rdWr_q,         rdWr_d;
    logic                  wrValid_q,      wrValid_d;
    logic                  regWriteWr_q,   regWriteWr_d;
    logic                  misalignWr_q,   misalignWr_d;

    logic [DATA_W-1:0]     selAddr;
    logic [1:0]            selSize;
    logic                  selUnsigned;
    logic                  selMemToReg;
    logic                  selMemWrite;
    logic                  selRegWrite;
    logic [REG_ADDR_W-1:0] selRt;
    logic [REG_ADDR_W-1:0] selRd;
    logic                  selAligned;
    logic                  selMisaligned;
    logic [DATA_W-1:0]     memRdata;
    logic [DATA_W-1:0]     loadValue;
    logic [DATA_W-1:0]     selResult;

    logic accept;
    logic acceptLong;
    logic acceptShort;
    logic finalWait;
    logic memWe;

    assign stall       = (state_q == WAIT);
    assign accept      = in_valid & ~stall;
    assign acceptLong  = accept & mem_to_reg & LONG_LAT;
    assign acceptShort = accept & ~(mem_to_reg & LONG_LAT);
    assign finalWait   = (state_q == WAIT) && (cnt_q == CNT_W'(1));

    // Pick the op being worked on: the live EX inputs when idle, the captured load while waiting.
    always_comb begin
        if (state_q == WAIT) begin
            selAddr     = capAddr_q;
            selSize     = capSize_q;
            selUnsigned = capUnsigned_q;
            selMemToReg = 1'b1;
            selMemWrite = 1'b0;
            selRegWrite = capRegWrite_q;
            selRt       = capRt_q;
            selRd       = capRd_q;
        end else begin
            selAddr     = mem_addr;
            selSize     = size;
            selUnsigned = load_unsigned;
            selMemToReg = mem_to_reg;
            selMemWrite = mem_write;
            selRegWrite = reg_write;
            selRt       = rt_mem;
            selRd       = rd_mem;
        end
    end

    assign selAligned    = isAligned(selSize, selAddr[1:0]);
    assign selMisaligned = (selMemWrite | selMemToReg) & ~selAligned;
    assign loadValue     = loadExtract(memRdata, selSize, selAddr[1:0], selUnsigned);
    assign selResult     = selMemToReg ? (selAligned ? loadValue : '0) : selAddr;

    // Stores only happen on an accept in IDLE, where the selected op is the live one.
    assign memWe = acceptShort & mem_write & selAligned & ~reset;

    data_mem_be #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_data_mem (
        .clk_i   (clk),
        .we_i    (memWe),
        .be_i    (byteEnable(size, mem_addr[1:0])),
        .addr_i  (selAddr[2 +: IDX_W]),
        .wdata_i (storeLanes(store_data, size)),
        .rdata_o (memRdata)
    );

    assign write_data_fwd = selResult;
    assign fwd_valid      = (acceptShort & reg_write) | finalWait;

    // Next-state for the latency FSM, load capture and MEM/WB register.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capAddr_d     = capAddr_q;
        capSize_d     = capSize_q;
        capUnsigned_d = capUnsigned_q;
        capRegWrite_d = capRegWrite_q;
        capRt_d       = capRt_q;
        capRd_d       = capRd_q;
        writeToReg_d  = writeToReg_q;
        rtWr_d        = rtWr_q;
        rdWr_d        = rdWr_q;
        wrValid_d     = 1'b0;
        regWriteWr_d  = 1'b0;
        misalignWr_d  = 1'b0;

        if (acceptShort || finalWait) begin
            wrValid_d    = 1'b1;
            regWriteWr_d = selRegWrite & ~selMisaligned;
            misalignWr_d = selMisaligned;
            writeToReg_d = selResult;
            rtWr_d       = selRt;
            rdWr_d       = selRd;
            if (finalWait) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (acceptLong) begin
            state_d       = WAIT;
            cnt_d         = CNT_W'(MEM_LATENCY - 1);
            capAddr_d     = mem_addr;
            capSize_d     = size;
            capUnsigned_d = load_unsigned;
            capRegWrite_d = reg_write;
            capRt_d       = rt_mem;
            capRd_d       = rd_mem;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State and pipeline registers; reset drops any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            capAddr_q     <= '0;
            capSize_q     <= '0;
            capUnsigned_q <= 1'b0;
            capRegWrite_q <= 1'b0;
            capRt_q       <= '0;
            capRd_q       <= '0;
            writeToReg_q  <= '0;
            rtWr_q        <= '0;
            rdWr_q        <= '0;
            wrValid_q     <= 1'b0;
            regWriteWr_q  <= 1'b0;
            misalignWr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            capAddr_q     <= capAddr_d;
            capSize_q     <= capSize_d;
            capUnsigned_q <= capUnsigned_d;
            capRegWrite_q <= capRegWrite_d;
            capRt_q       <= capRt_d;
            capRd_q       <= capRd_d;
            writeToReg_q  <= writeToReg_d;
            rtWr_q        <= rtWr_d;
            rdWr_q        <= rdWr_d;
            wrValid_q     <= wrValid_d;
            regWriteWr_q  <= regWriteWr_d;
            misalignWr_q  <= misalignWr_d;
        end
    end

    assign write_to_reg = writeToReg_q;
    assign rt_wr        = rtWr_q;
    assign rd_wr        = rdWr_q;
    assign wr_valid     = wrValid_q;
    assign reg_write_wr = regWriteWr_q;
    assign misalign_wr  = misalignWr_q;

endmodule
